// File: rtl/ritc_idelay_eye_trainer.sv
// Per-lane IDELAY eye trainer: sweeps every tap, measures capture stability, finds the
// longest stable window, writes its centre tap back and reports the eye per lane.
module ritc_idelay_eye_trainer #(
    parameter int unsigned NTAPS         = 32,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned DWELL_CYCLES  = 256,
    parameter int unsigned MIN_WIDTH     = 4
) (
    input  logic        SYSCLK,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [11:0] bit_mask_i,
    input  logic [47:0] ch_dat_i,
    output logic        dly_wr_o,
    output logic [3:0]  dly_bit_o,
    output logic [4:0]  dly_val_o,
    input  logic        dly_ack_i,
    output logic        busy_o,
    output logic        res_valid_o,
    output logic [3:0]  res_bit_o,
    output logic [4:0]  res_start_o,
    output logic [5:0]  res_width_o,
    output logic [4:0]  res_center_o,
    output logic        res_fail_o,
    output logic        done_o
);

    typedef enum logic [3:0] {
        StIdle, StSetTap, StSettle, StDwell, StEval, StSetCenter, StReport, StNextBit, StDone
    } state_t;

    localparam logic [4:0]  LastTap   = 5'(NTAPS - 1);
    localparam logic [15:0] SettleEnd = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] DwellEnd  = 16'(DWELL_CYCLES - 1);
    localparam logic [5:0]  MinWidth  = 6'(MIN_WIDTH);

    state_t      state_q;
    logic [11:0] mask_q;
    logic [3:0]  bit_q;
    logic [4:0]  tap_q;
    logic [15:0] cnt_q;
    logic [3:0]  ref_q;
    logic        err_q;
    logic [4:0]  cur_start_q;
    logic [5:0]  cur_len_q;
    logic [4:0]  best_start_q;
    logic [5:0]  best_len_q;

    logic [11:0] smp [4];
    logic [3:0]  nib;
    logic [3:0]  nxt_bit;
    logic        good;
    logic        close_run;
    logic [5:0]  eval_len;
    logic [4:0]  eval_start;
    logic [5:0]  new_best_len;
    logic [4:0]  new_best_start;
    logic [5:0]  center_sum;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            smp[k] = ch_dat_i[12*k +: 12];
            nib[k] = smp[k][bit_q];
        end
    end

    // Descending scan so the lowest set lane wins.
    always_comb begin
        nxt_bit = '0;
        for (int i = 11; i >= 0; i--) begin
            if (mask_q[i]) nxt_bit = 4'(i);
        end
    end

    // Run bookkeeping for the current tap; the centre is derived from the post-EVAL best run
    // so the final write can be launched straight out of EVAL.
    always_comb begin
        good       = !err_q;
        eval_len   = good ? cur_len_q + 6'd1 : cur_len_q;
        eval_start = (good && cur_len_q == 6'd0) ? tap_q : cur_start_q;
        close_run  = !good || (tap_q == LastTap);
        new_best_len   = best_len_q;
        new_best_start = best_start_q;
        if (close_run && eval_len > best_len_q) begin
            new_best_len   = eval_len;
            new_best_start = eval_start;
        end
        center_sum = {1'b0, new_best_start} + (new_best_len >> 1);
    end

    always_ff @(posedge SYSCLK) begin
        if (rst_i) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            bit_q        <= '0;
            tap_q        <= '0;
            cnt_q        <= '0;
            ref_q        <= '0;
            err_q        <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            dly_wr_o     <= 1'b0;
            dly_bit_o    <= '0;
            dly_val_o    <= '0;
            busy_o       <= 1'b0;
            res_valid_o  <= 1'b0;
            res_bit_o    <= '0;
            res_start_o  <= '0;
            res_width_o  <= '0;
            res_center_o <= '0;
            res_fail_o   <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            res_valid_o <= 1'b0;
            done_o      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mask_q  <= bit_mask_i;
                        busy_o  <= 1'b1;
                        state_q <= StNextBit;
                    end
                end
                StNextBit: begin
                    if (mask_q == '0) begin
                        done_o  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        bit_q        <= nxt_bit;
                        mask_q       <= mask_q & ~(12'd1 << nxt_bit);
                        tap_q        <= '0;
                        err_q        <= 1'b0;
                        cur_start_q  <= '0;
                        cur_len_q    <= '0;
                        best_start_q <= '0;
                        best_len_q   <= '0;
                        dly_wr_o     <= 1'b1;
                        dly_bit_o    <= nxt_bit;
                        dly_val_o    <= '0;
                        state_q      <= StSetTap;
                    end
                end
                StSetTap: begin
                    if (dly_ack_i) begin
                        dly_wr_o <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q == SettleEnd) begin
                        cnt_q   <= '0;
                        state_q <= StDwell;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StDwell: begin
                    if (cnt_q == '0) begin
                        ref_q <= nib;
                        err_q <= 1'b0;
                    end else if (nib != ref_q) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == DwellEnd) begin
                        cnt_q   <= '0;
                        state_q <= StEval;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StEval: begin
                    best_len_q   <= new_best_len;
                    best_start_q <= new_best_start;
                    cur_len_q    <= close_run ? 6'd0 : eval_len;
                    cur_start_q  <= eval_start;
                    dly_wr_o     <= 1'b1;
                    if (tap_q == LastTap) begin
                        dly_val_o <= center_sum[4:0];
                        state_q   <= StSetCenter;
                    end else begin
                        tap_q     <= tap_q + 5'd1;
                        dly_val_o <= tap_q + 5'd1;
                        state_q   <= StSetTap;
                    end
                end
                StSetCenter: begin
                    if (dly_ack_i) begin
                        dly_wr_o     <= 1'b0;
                        res_valid_o  <= 1'b1;
                        res_bit_o    <= bit_q;
                        res_start_o  <= best_start_q;
                        res_width_o  <= best_len_q;
                        res_center_o <= dly_val_o;
                        res_fail_o   <= best_len_q < MinWidth;
                        state_q      <= StReport;
                    end
                end
                StReport: state_q <= StNextBit;
                StDone: begin
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ritc_idelay_eye_trainer.sv
// Directed bench for the eye trainer: a lane model that is stable only on chosen taps,
// an IDELAY ack responder, and a result scoreboard.
module tb_ritc_idelay_eye_trainer;

    localparam int unsigned Settle = 4;
    localparam int unsigned Dwell  = 16;

    logic        SYSCLK;
    logic        rst_i;
    logic        start_i;
    logic [11:0] bit_mask_i;
    logic [47:0] ch_dat_i;
    logic        dly_wr_o;
    logic [3:0]  dly_bit_o;
    logic [4:0]  dly_val_o;
    logic        dly_ack_i;
    logic        busy_o;
    logic        res_valid_o;
    logic [3:0]  res_bit_o;
    logic [4:0]  res_start_o;
    logic [5:0]  res_width_o;
    logic [4:0]  res_center_o;
    logic        res_fail_o;
    logic        done_o;

    ritc_idelay_eye_trainer #(
        .NTAPS(32),
        .SETTLE_CYCLES(Settle),
        .DWELL_CYCLES(Dwell),
        .MIN_WIDTH(4)
    ) dut (
        .SYSCLK(SYSCLK),
        .rst_i(rst_i),
        .start_i(start_i),
        .bit_mask_i(bit_mask_i),
        .ch_dat_i(ch_dat_i),
        .dly_wr_o(dly_wr_o),
        .dly_bit_o(dly_bit_o),
        .dly_val_o(dly_val_o),
        .dly_ack_i(dly_ack_i),
        .busy_o(busy_o),
        .res_valid_o(res_valid_o),
        .res_bit_o(res_bit_o),
        .res_start_o(res_start_o),
        .res_width_o(res_width_o),
        .res_center_o(res_center_o),
        .res_fail_o(res_fail_o),
        .done_o(done_o)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        logic [3:0] lane;
        logic [4:0] start;
        logic [5:0] width;
        logic [4:0] center;
        logic       fail;
    } res_t;

    res_t        exp_q[$];
    res_t        mon_r;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] stable [16];
    logic [4:0]  tb_tap [16];
    logic [4:0]  last_wr_val = '0;
    logic        tog = 1'b0;
    logic [47:0] dat;
    logic [3:0]  nib;
    logic        ack_en = 1'b1;
    logic        spur = 1'b0;
    int          ack_lat = 0;
    int          wr_age = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    task automatic push(input int lane, input int st, input int w, input int c, input logic f);
        res_t r;
        r.lane   = 4'(lane);
        r.start  = 5'(st);
        r.width  = 6'(w);
        r.center = 5'(c);
        r.fail   = f;
        exp_q.push_back(r);
    endtask

    // Physical model: the IDELAY tap of each lane follows accepted writes.
    always @(posedge SYSCLK) begin
        if (dly_wr_o && dly_ack_i) begin
            tb_tap[dly_bit_o] <= dly_val_o;
            last_wr_val       <= dly_val_o;
        end
    end

    // Stable taps return a fixed nibble, others alternate every cycle.
    always @(negedge SYSCLK) begin
        tog = ~tog;
        for (int b = 0; b < 12; b++) begin
            nib = stable[b][tb_tap[b]] ? 4'hA : (tog ? 4'h5 : 4'hA);
            for (int k = 0; k < 4; k++) dat[12*k+b] = nib[k];
        end
        ch_dat_i = dat;
        if (dly_wr_o) wr_age++;
        else wr_age = 0;
        dly_ack_i = ack_en && (dly_wr_o ? (wr_age > ack_lat) : spur);
    end

    always @(negedge SYSCLK) begin
        if (res_valid_o) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL res_unexpected: observed result for lane %0d expected none", res_bit_o);
            end
            if (exp_q.size() != 0) begin
                mon_r = exp_q.pop_front();
                check("res_lane", 64'(res_bit_o), 64'(mon_r.lane));
                check("res_start", 64'(res_start_o), 64'(mon_r.start));
                check("res_width", 64'(res_width_o), 64'(mon_r.width));
                check("res_center", 64'(res_center_o), 64'(mon_r.center));
                check("res_fail", 64'(res_fail_o), 64'(mon_r.fail));
                check("last_dly_val", 64'(last_wr_val), 64'(mon_r.center));
            end
        end
    end

    task automatic run_scan(input string tag, input logic [11:0] mask, input int exp_lat,
                            input int poke_at, input logic [11:0] poke_mask);
        int cyc;
        @(negedge SYSCLK);
        bit_mask_i = mask;
        start_i    = 1'b1;
        @(negedge SYSCLK);
        start_i = 1'b0;
        cyc     = 1;
        check({tag, "_busy"}, 64'(busy_o), 64'd1);
        while (!done_o && cyc < 20000) begin
            @(negedge SYSCLK);
            cyc++;
            if (cyc == poke_at) begin
                bit_mask_i = poke_mask;
                start_i    = 1'b1;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        check({tag, "_done"}, 64'(done_o), 64'd1);
        if (exp_lat > 0) check({tag, "_done_lat"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        @(negedge SYSCLK);
        check({tag, "_idle"}, 64'({busy_o, done_o}), 64'd0);
    endtask

    initial begin
        int dones;
        rst_i      = 1'b1;
        start_i    = 1'b0;
        bit_mask_i = '0;
        ch_dat_i   = '0;
        dly_ack_i  = 1'b0;
        for (int b = 0; b < 16; b++) begin
            stable[b] = '0;
            tb_tap[b] = '0;
        end
        repeat (3) @(negedge SYSCLK);
        check("reset_outputs", 64'({dly_wr_o, dly_bit_o, dly_val_o, busy_o, res_valid_o,
              res_bit_o, res_start_o, res_width_o, res_center_o, res_fail_o, done_o}), 64'd0);
        rst_i = 1'b0;

        stable[0] = win(10, 19);
        push(0, 10, 10, 15, 1'b0);
        run_scan("single_window", 12'h001, 0, 0, 12'h000);

        stable[0] = win(3, 5) | win(20, 27);
        push(0, 20, 8, 24, 1'b0);
        run_scan("longest_wins", 12'h001, 0, 0, 12'h000);

        stable[0] = win(2, 5) | win(12, 15);
        push(0, 2, 4, 4, 1'b0);
        run_scan("tie_earliest", 12'h001, 0, 0, 12'h000);

        stable[0] = '0;
        push(0, 0, 0, 0, 1'b1);
        run_scan("no_eye", 12'h001, 0, 0, 12'h000);

        stable[0] = win(24, 31);
        push(0, 24, 8, 28, 1'b0);
        run_scan("window_at_end", 12'h001, 0, 0, 12'h000);

        // Slow acks plus stray acks between writes.
        stable[0]  = win(10, 19);
        stable[11] = win(24, 31);
        ack_lat    = 2;
        spur       = 1'b1;
        push(0, 10, 10, 15, 1'b0);
        push(11, 24, 8, 28, 1'b0);
        run_scan("two_lanes", 12'h801, 0, 0, 12'h000);
        ack_lat = 0;
        spur    = 1'b0;

        run_scan("zero_mask", 12'h000, 2, 0, 12'h000);

        // Abort mid-handshake: ack withheld so the first tap write stays pending.
        ack_en = 1'b0;
        @(negedge SYSCLK);
        bit_mask_i = 12'h001;
        start_i    = 1'b1;
        @(negedge SYSCLK);
        start_i = 1'b0;
        repeat (10) @(negedge SYSCLK);
        check("pending_write", 64'(dly_wr_o), 64'd1);
        rst_i = 1'b1;
        @(negedge SYSCLK);
        check("abort_outputs", 64'({dly_wr_o, dly_bit_o, dly_val_o, busy_o, res_valid_o,
              res_bit_o, res_start_o, res_width_o, res_center_o, res_fail_o, done_o}), 64'd0);
        rst_i  = 1'b0;
        ack_en = 1'b1;
        dones  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge SYSCLK);
            if (done_o) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        stable[0] = win(10, 19);
        stable[1] = win(0, 31);
        push(0, 10, 10, 15, 1'b0);
        run_scan("restart_ignore_start", 12'h001, 0, 100, 12'h002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
